// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA-256 types, constants, FSM encoding and pass-2 padding
// Purpose: common definitions for the nonce scheduler and its core interface.
// Ports: none (package).
package sha_pkg;

    typedef logic [0:255] digest_t;
    typedef logic [0:255] chain_t;
    typedef logic [0:511] block_t;

    localparam chain_t SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [3:0] {
        S_IDLE,
        S_P1_ISSUE,
        S_P1_WAIT,
        S_P2_ISSUE,
        S_P2_WAIT,
        S_CHECK,
        S_FOUND,
        S_DONE,
        S_FAULT
    } sched_state_e;

    // Second pass hashes the 256-bit first digest as a single padded block:
    // digest, a '1' marker bit, zero fill, and the 64-bit message length (256).
    function automatic block_t pass2_block(input digest_t d);
        return {d, 1'b1, 191'b0, 64'd256};
    endfunction

endpackage

// File: rtl/nonce_scheduler_if.sv
// rtl/nonce_scheduler_if.sv - handshake bundle between the scheduler and the compression core
// Purpose: groups the core launch/result signals.
// Signals: core_start (launch pulse), core_state (chaining input), core_block (message block),
//          core_done (completion pulse), core_digest (result, valid with core_done).
// Modports: master = scheduler side, slave = compression core side.
interface nonce_scheduler_if;
    import sha_pkg::*;

    logic    core_start;
    chain_t  core_state;
    block_t  core_block;
    logic    core_done;
    digest_t core_digest;

    modport master (
        output core_start,
        output core_state,
        output core_block,
        input  core_done,
        input  core_digest
    );

    modport slave (
        input  core_start,
        input  core_state,
        input  core_block,
        output core_done,
        output core_digest
    );

endinterface

// File: rtl/nonce_hit_check.sv
// rtl/nonce_hit_check.sv - combinational zero-bit target compare on a final digest
// Purpose: flags a hit when the last ZERO_BITS digest bits (indices 256-ZERO_BITS..255) are all 0.
// Ports: digest (in, pass-2 digest), hit (out, 1 = target met). ZERO_BITS = 0 always hits.
module nonce_hit_check
    import sha_pkg::*;
#(
    parameter int ZERO_BITS = 16
) (
    input  digest_t digest,
    output logic    hit
);

    // Loop form keeps ZERO_BITS = 0 legal without a zero-width slice.
    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if ((i >= 256 - ZERO_BITS) && digest[i]) begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - double-SHA-256 nonce search sequencer for one shared compression core
// Purpose: per nonce, runs pass 1 (midstate, block2 with nonce inserted) then pass 2
//          (IV, padded pass-1 digest) and compares the pass-2 digest against the zero-bit target.
// Ports: clk, rst (async, active-high); start/abort pulses; midstate, block2, nonce_start,
//        nonce_end (sampled on accepted start); core (master side of the core handshake);
//        busy, found, golden_nonce, exhausted, error, hash_count, led status outputs.
module nonce_scheduler
    import sha_pkg::*;
#(
    parameter int ZERO_BITS   = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int NONCE_LSB   = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  chain_t                   midstate,
    input  block_t                   block2,
    input  logic [31:0]              nonce_start,
    input  logic [31:0]              nonce_end,
    nonce_scheduler_if.master        core,
    output logic                     busy,
    output logic                     found,
    output logic [31:0]              golden_nonce,
    output logic                     exhausted,
    output logic                     error,
    output logic [31:0]              hash_count,
    output logic                     led
);

    sched_state_e state;
    sched_state_e next_state;

    chain_t      midstate_q;
    block_t      block2_q;
    digest_t     digest2;
    logic [31:0] nonce;
    logic [31:0] nonce_end_q;
    logic [31:0] wait_cnt;

    logic        accept_start;
    logic        in_wait;
    logic        timeout;
    logic        hit;
    logic [31:0] p1_nonce;
    chain_t      p1_state;
    block_t      p1_block;

    function automatic block_t insert_nonce(input block_t blk, input logic [31:0] n);
        block_t b;
        b = blk;
        b[NONCE_LSB +: 32] = n;
        return b;
    endfunction

    nonce_hit_check #(
        .ZERO_BITS (ZERO_BITS)
    ) u_hit_check (
        .digest (digest2),
        .hit    (hit)
    );

    assign busy            = !(state inside {S_IDLE, S_FOUND, S_DONE, S_FAULT});
    assign accept_start    = start && !busy;
    assign in_wait         = (state == S_P1_WAIT) || (state == S_P2_WAIT);
    assign core.core_start = (state == S_P1_ISSUE) || (state == S_P2_ISSUE);

    // wait_cnt holds the number of cycles since the core_start cycle, so the
    // FAULT state (and error) appears exactly TIMEOUT_CYC cycles after core_start.
    assign timeout = in_wait && !core.core_done && (wait_cnt == 32'(TIMEOUT_CYC - 1));

    // Pass-1 operands: straight from the ports on the launching start, from the
    // latched copies when advancing to the next nonce.
    assign p1_nonce = accept_start ? nonce_start : nonce + 32'd1;
    assign p1_state = accept_start ? midstate    : midstate_q;
    assign p1_block = accept_start ? block2      : block2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_FOUND, S_DONE, S_FAULT: begin
                if (start) begin
                    next_state = S_P1_ISSUE;
                end
            end
            S_P1_ISSUE: next_state = S_P1_WAIT;
            S_P1_WAIT: begin
                if (core.core_done) begin
                    next_state = S_P2_ISSUE;
                end else if (timeout) begin
                    next_state = S_FAULT;
                end
            end
            S_P2_ISSUE: next_state = S_P2_WAIT;
            S_P2_WAIT: begin
                if (core.core_done) begin
                    next_state = S_CHECK;
                end else if (timeout) begin
                    next_state = S_FAULT;
                end
            end
            S_CHECK: begin
                if (hit) begin
                    next_state = S_FOUND;
                end else if (nonce == nonce_end_q) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_P1_ISSUE;
                end
            end
            default: next_state = S_IDLE;
        endcase
        // abort overrides every outcome, including a coincident core_done.
        if (busy && abort) begin
            next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            midstate_q      <= '0;
            block2_q        <= '0;
            nonce_end_q     <= '0;
            nonce           <= '0;
            digest2         <= '0;
            wait_cnt        <= '0;
            core.core_state <= '0;
            core.core_block <= '0;
            found           <= 1'b0;
            golden_nonce    <= '0;
            exhausted       <= 1'b0;
            error           <= 1'b0;
            hash_count      <= '0;
            led             <= 1'b0;
        end else begin
            led <= found;

            if (accept_start) begin
                found       <= 1'b0;
                exhausted   <= 1'b0;
                error       <= 1'b0;
                hash_count  <= '0;
                midstate_q  <= midstate;
                block2_q    <= block2;
                nonce_end_q <= nonce_end;
            end

            // Core operands are loaded on entry to an ISSUE state and then held
            // untouched until the matching core_done.
            if (next_state == S_P1_ISSUE) begin
                nonce           <= p1_nonce;
                core.core_state <= p1_state;
                core.core_block <= insert_nonce(p1_block, p1_nonce);
            end

            // The pass-1 digest lives only inside the pass-2 block register.
            if (state == S_P1_WAIT && next_state == S_P2_ISSUE) begin
                core.core_state <= SHA256_IV;
                core.core_block <= pass2_block(core.core_digest);
            end

            if (state == S_P2_WAIT && next_state == S_CHECK) begin
                digest2    <= core.core_digest;
                hash_count <= hash_count + 32'd1;
            end

            if (state == S_CHECK && next_state == S_FOUND) begin
                golden_nonce <= nonce;
                found        <= 1'b1;
            end

            if (state == S_CHECK && next_state == S_DONE) begin
                exhausted <= 1'b1;
            end

            if (in_wait && next_state == S_FAULT) begin
                error <= 1'b1;
            end

            if (core.core_start) begin
                wait_cnt <= 32'd1;
            end else if (in_wait) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end

endmodule
